// File: rtl/alu_cmd_driver.sv
// Operator front-end for the 4-bit lab ALU: debounced button steps through
// operand/opcode entry, waits for the ALU to settle, then latches its result.
module alu_cmd_driver #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_data,
  input  logic       btn_next,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_f,
  input  logic       alu_cf,
  input  logic       alu_of,
  input  logic       alu_zero,
  output logic [3:0] result_f,
  output logic [2:0] result_flags,
  output logic       result_valid,
  output logic [2:0] stage
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_WAIT = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t          state;
  logic            sync0, sync1;
  logic            db_level;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic [ST_W-1:0] settle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= btn_next;
      sync1 <= sync0;
    end
  end

  // Level resets high so a button held through reset must be released first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt   <= '0;
      db_level <= 1'b1;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync1 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= ~db_level;
          db_cnt   <= '0;
          press    <= ~db_level;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      result_f     <= '0;
      result_flags <= '0;
      result_valid <= 1'b0;
      settle       <= '0;
    end else begin
      case (state)
        S_A: if (press) begin
          alu_a <= sw_data;
          state <= S_B;
        end
        S_B: if (press) begin
          alu_b <= sw_data;
          state <= S_OP;
        end
        S_OP: if (press) begin
          alu_op <= sw_data[2:0];
          settle <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (settle == ST_LAST) begin
            result_f     <= alu_f;
            result_flags <= {alu_cf, alu_of, alu_zero};
            result_valid <= 1'b1;
            state        <= S_SHOW;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        S_SHOW: if (press) begin
          result_valid <= 1'b0;
          state        <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

  assign stage = state;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: a table of ALU operations plus hand-timed
// sequences for debounce latency, bounce, presses during settle and mid-op reset.
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw = '0;
  logic       btn = 1'b1;
  logic       btn8 = 1'b0;

  logic [3:0] alu_a, alu_b, alu_f, result_f;
  logic [2:0] alu_op, result_flags, stage;
  logic       alu_cf, alu_of, alu_zero, result_valid;

  logic [3:0] alu_a8, alu_b8, alu_f8, result_f8;
  logic [2:0] alu_op8, result_flags8, stage8;
  logic       alu_cf8, alu_of8, alu_zero8, result_valid8;

  logic       ovr = 1'b0;
  logic [3:0] ovr_f = '0;
  logic [2:0] ovr_flags = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t_wait = 0, t_valid = 0, t_wait8 = 0, t_valid8 = 0;
  logic [2:0] prev_stage = '0, prev_stage8 = '0;
  logic       prev_valid = 1'b0, prev_valid8 = 1'b0;

  always #5 clk = ~clk;

  // Behavioural 4-bit signed ALU: returns {f, cf, of, zero}; sub reports borrow as CF.
  function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] f;
    logic       cf, of;
    s = '0; f = '0; cf = 1'b0; of = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        f = s[3:0]; cf = s[4];
        of = (a[3] == b[3]) && (f[3] != a[3]);
      end
      3'd1: begin
        f = a - b; cf = (a < b);
        of = (a[3] != b[3]) && (f[3] != a[3]);
      end
      3'd2: f = ~a;
      3'd3: f = a & b;
      3'd4: f = a | b;
      3'd5: f = a ^ b;
      3'd6: f = ($signed(a) > $signed(b)) ? 4'd1 : 4'd0;
      default: f = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {f, cf, of, (f == 4'd0)};
  endfunction

  logic [6:0] m1, m8;
  assign m1 = alu_model(alu_a, alu_b, alu_op);
  assign m8 = alu_model(alu_a8, alu_b8, alu_op8);
  assign alu_f    = ovr ? ovr_f        : m1[6:3];
  assign alu_cf   = ovr ? ovr_flags[2] : m1[2];
  assign alu_of   = ovr ? ovr_flags[1] : m1[1];
  assign alu_zero = ovr ? ovr_flags[0] : m1[0];
  assign alu_f8    = m8[6:3];
  assign alu_cf8   = m8[2];
  assign alu_of8   = m8[1];
  assign alu_zero8 = m8[0];

  alu_cmd_driver #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .sw_data(sw), .btn_next(btn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_f(alu_f), .alu_cf(alu_cf), .alu_of(alu_of), .alu_zero(alu_zero),
    .result_f(result_f), .result_flags(result_flags),
    .result_valid(result_valid), .stage(stage)
  );

  alu_cmd_driver #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(8)) u_dut8 (
    .clk(clk), .rst(rst), .sw_data(sw), .btn_next(btn8),
    .alu_a(alu_a8), .alu_b(alu_b8), .alu_op(alu_op8),
    .alu_f(alu_f8), .alu_cf(alu_cf8), .alu_of(alu_of8), .alu_zero(alu_zero8),
    .result_f(result_f8), .result_flags(result_flags8),
    .result_valid(result_valid8), .stage(stage8)
  );

  always @(posedge clk) begin
    cyc++;
    #1;
    if (stage == 3'd3 && prev_stage != 3'd3) t_wait = cyc;
    if (result_valid && !prev_valid) t_valid = cyc;
    if (stage8 == 3'd3 && prev_stage8 != 3'd3) t_wait8 = cyc;
    if (result_valid8 && !prev_valid8) t_valid8 = cyc;
    prev_stage  = stage;
    prev_valid  = result_valid;
    prev_stage8 = stage8;
    prev_valid8 = result_valid8;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input bit which);
    if (which) btn8 = 1'b1; else btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    btn8 = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic check_capture(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic [2:0] op, input logic [3:0] f,
                               input logic [2:0] flags);
    chk({tag, "_stage"}, stage, 3'd4);
    chk({tag, "_valid"}, result_valid, 1'b1);
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_op"}, alu_op, op);
    chk({tag, "_f"}, result_f, f);
    chk({tag, "_flags"}, result_flags, flags);
    chk({tag, "_latency"}, t_valid - t_wait, 2);
  endtask

  task automatic hold_and_return(input string tag, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] f, input logic [2:0] flags);
    sw = ~a;
    ovr = 1'b1; ovr_f = ~f; ovr_flags = ~flags;
    repeat (6) @(negedge clk);
    chk({tag, "_hold_f"}, result_f, f);
    chk({tag, "_hold_flags"}, result_flags, flags);
    chk({tag, "_hold_a"}, alu_a, a);
    chk({tag, "_hold_b"}, alu_b, b);
    ovr = 1'b0;
    press(1'b0);
    chk({tag, "_ret_stage"}, stage, 3'd0);
    chk({tag, "_ret_valid"}, result_valid, 1'b0);
    chk({tag, "_ret_a"}, alu_a, a);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sw_op;
    logic [2:0] exp_op;
    logic [3:0] exp_f;
    logic [2:0] exp_flags;
  } vec_t;

  vec_t vecs[12];

  typedef struct {
    logic       level;
    int         cycles;
  } bounce_t;

  bounce_t bnc[12];

  initial begin
    logic any_valid;
    vecs[0]  = '{4'h3, 4'h3, 4'h1, 3'd1, 4'h0, 3'b001};
    vecs[1]  = '{4'h5, 4'h0, 4'h2, 3'd2, 4'hA, 3'b000};
    vecs[2]  = '{4'hC, 4'hA, 4'h3, 3'd3, 4'h8, 3'b000};
    vecs[3]  = '{4'h0, 4'h0, 4'h4, 3'd4, 4'h0, 3'b001};
    vecs[4]  = '{4'hF, 4'hF, 4'h5, 3'd5, 4'h0, 3'b001};
    vecs[5]  = '{4'h1, 4'hF, 4'h6, 3'd6, 4'h1, 3'b000};
    vecs[6]  = '{4'h8, 4'h7, 4'h6, 3'd6, 4'h0, 3'b001};
    vecs[7]  = '{4'h8, 4'h1, 4'h1, 3'd1, 4'h7, 3'b010};
    vecs[8]  = '{4'h2, 4'h5, 4'h1, 3'd1, 4'hD, 3'b100};
    vecs[9]  = '{4'hF, 4'h1, 4'h0, 3'd0, 4'h0, 3'b101};
    vecs[10] = '{4'h6, 4'h6, 4'h7, 3'd7, 4'h1, 3'b000};
    vecs[11] = '{4'h6, 4'h3, 4'hD, 3'd5, 4'h5, 3'b000};

    bnc[0] = '{1'b1, 2};  bnc[1]  = '{1'b0, 1};  bnc[2]  = '{1'b1, 3};
    bnc[3] = '{1'b0, 2};  bnc[4]  = '{1'b1, 1};  bnc[5]  = '{1'b0, 3};
    bnc[6] = '{1'b1, 12}; bnc[7]  = '{1'b0, 1};  bnc[8]  = '{1'b1, 2};
    bnc[9] = '{1'b0, 3};  bnc[10] = '{1'b1, 1};  bnc[11] = '{1'b0, 12};

    // Reset with the button held, then release reset and later the button.
    repeat (3) @(negedge clk);
    chk("rst_alu_a", alu_a, 4'h0);
    chk("rst_alu_b", alu_b, 4'h0);
    chk("rst_alu_op", alu_op, 3'd0);
    chk("rst_result_f", result_f, 4'h0);
    chk("rst_flags", result_flags, 3'd0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_stage", stage, 3'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_btn_stage", stage, 3'd0);
    btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("release_stage", stage, 3'd0);

    // Press latency: 2 sync + 4 debounce cycles, then the FSM edge.
    sw = 4'h7;
    btn = 1'b1;
    repeat (6) @(negedge clk);
    chk("press_early_stage", stage, 3'd0);
    @(negedge clk);
    chk("press_stage", stage, 3'd1);
    chk("press_alu_a", alu_a, 4'h7);
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (10) @(negedge clk);

    // Bouncy press for B: exactly one advance.
    sw = 4'h1;
    for (int i = 0; i < 12; i++) begin
      btn = bnc[i].level;
      repeat (bnc[i].cycles) @(negedge clk);
    end
    chk("bounce_stage", stage, 3'd2);
    chk("bounce_alu_b", alu_b, 4'h1);

    sw = 4'h0;
    press(1'b0);
    check_capture("v_add7", 4'h7, 4'h1, 3'd0, 4'h8, 3'b010);
    hold_and_return("v_add7", 4'h7, 4'h1, 4'h8, 3'b010);

    for (int i = 0; i < 12; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      sw = vecs[i].a;
      press(1'b0);
      chk({tag, "_stage_b"}, stage, 3'd1);
      sw = vecs[i].b;
      press(1'b0);
      chk({tag, "_stage_op"}, stage, 3'd2);
      sw = vecs[i].sw_op;
      press(1'b0);
      check_capture(tag, vecs[i].a, vecs[i].b, vecs[i].exp_op, vecs[i].exp_f, vecs[i].exp_flags);
      hold_and_return(tag, vecs[i].a, vecs[i].b, vecs[i].exp_f, vecs[i].exp_flags);
    end

    // SETTLE_CYCLES=8 instance: a second press lands while still waiting.
    sw = 4'h2;
    press(1'b1);
    sw = 4'h3;
    press(1'b1);
    chk("s8_stage_op", stage8, 3'd2);
    sw = 4'h0;
    btn8 = 1'b1;
    repeat (4) @(negedge clk);
    btn8 = 1'b0;
    repeat (4) @(negedge clk);
    btn8 = 1'b1;
    repeat (10) @(negedge clk);
    btn8 = 1'b0;
    repeat (10) @(negedge clk);
    chk("s8_stage", stage8, 3'd4);
    chk("s8_valid", result_valid8, 1'b1);
    chk("s8_latency", t_valid8 - t_wait8, 8);
    chk("s8_f", result_f8, 4'h5);
    chk("s8_flags", result_flags8, 3'b000);

    // Reset asserted mid-settle on the main instance.
    sw = 4'hF;
    press(1'b0);
    sw = 4'h1;
    press(1'b0);
    sw = 4'h0;
    btn = 1'b1;
    repeat (7) @(negedge clk);
    chk("mid_wait_stage", stage, 3'd3);
    rst = 1'b1;
    #1;
    chk("arst_stage", stage, 3'd0);
    chk("arst_alu_a", alu_a, 4'h0);
    chk("arst_alu_b", alu_b, 4'h0);
    chk("arst_alu_op", alu_op, 3'd0);
    chk("arst_result_f", result_f, 4'h0);
    chk("arst_flags", result_flags, 3'd0);
    chk("arst_valid", result_valid, 1'b0);
    repeat (3) @(negedge clk);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_valid = any_valid | result_valid;
    end
    chk("post_rst_valid", any_valid, 1'b0);
    chk("post_rst_stage", stage, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Front-end sequencer that initiates operations on the lab's 4-bit signed two's-complement ALU.
- The operator enters A, B and the opcode in turn from 4 slide switches, confirming each with one push button.
- The block drives registered operands and opcode to the ALU, waits a settle interval, then captures the ALU result and flags into display registers.
- It sits between board switches/buttons and the ALU; its outputs feed the ALU inputs and the board LEDs/7-seg decoder.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed for the button to change state (benches use 4)
SETTLE_CYCLES, 2, cycles held in S_WAIT before capturing the ALU outputs (minimum 1)

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  asynchronous, active-high reset
sw_data  input  4  switch value; sw_data[2:0] is the opcode in S_OP
btn_next  input  1  raw asynchronous push button, active-high
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_op  output  3  registered opcode to ALU (0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 signed greater-than, 7 equal)
alu_f  input  4  ALU result
alu_cf  input  1  ALU carry flag
alu_of  input  1  ALU overflow flag
alu_zero  input  1  ALU zero flag
result_f  output  4  captured result
result_flags  output  3  captured {CF, OF, ZERO}
result_valid  output  1  high while result_f and result_flags hold a capture
stage  output  3  current state encoding, for LEDs

Behaviour:
- Reset (async, active-high): alu_a=0, alu_b=0, alu_op=0, result_f=0, result_flags=0, result_valid=0, stage=S_A; sync flops=0; debounce counter=0; debounced level=1.
  - A button held through reset therefore produces no press until released and pressed again.
- Button path: 2-flop synchronizer, then debounce.
  - Counter increments on each cycle where the synchronized button differs from the debounced level, and clears on any cycle they agree.
  - On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - press = one-cycle pulse on a 0->1 debounced transition. Exactly one pulse per physical press; release produces no pulse.
- FSM states and stage encoding: S_A=0, S_B=1, S_OP=2, S_WAIT=3, S_SHOW=4. Codes 5-7 are unreachable; if entered, the next state is S_A.
- S_A: on press, alu_a<=sw_data; go to S_B.
- S_B: on press, alu_b<=sw_data; go to S_OP.
- S_OP: on press, alu_op<=sw_data[2:0]; settle counter<=0; go to S_WAIT.
- S_WAIT: counter increments each cycle; presses are ignored.
  - When the counter equals SETTLE_CYCLES-1: result_f<=alu_f, result_flags<={alu_cf,alu_of,alu_zero}, result_valid<=1; go to S_SHOW.
  - result_valid rises SETTLE_CYCLES cycles after the clock edge that loaded alu_op.
- S_SHOW: result registers hold regardless of ALU input changes. On press: result_valid<=0, go to S_A.
  - alu_a, alu_b, alu_op are not cleared, so the ALU keeps showing the previous operation until overwritten.
- Operand registers change only on their own capture edge; switch changes at any other time have no effect.
- Press coincident with a state's capture is handled by that state only, one transition per press.
- Reset asserted mid-operation (any state, including S_WAIT) returns immediately to the reset values. No partial capture survives.
- No arithmetic is done in this block; widths pass through unchanged. Upper switch bit sw_data[3] is ignored in S_OP.

Test Plan:
- Reset with btn_next held high, then release: no stage change; all outputs 0, stage=0. A subsequent press moves stage to 1 only after 2+4 cycles of stable high (DEBOUNCE_CYCLES=4).
- Button bounce of 1-3 cycle glitches around one press -> exactly one press pulse, stage advances by exactly 1.
- Enter A=7, B=1, op=0 with the ALU model connected -> alu_a=4'h7, alu_b=4'h1, alu_op=0; result_valid high exactly SETTLE_CYCLES=2 cycles after the op load; result_f=4'h8, result_flags=3'b010.
- Enter A=3, B=3, op=1 -> result_f=0, result_flags=3'b001. Change switches in S_SHOW: result and alu_a/alu_b unchanged. Next press: result_valid=0, stage=0.
- Press during S_WAIT (SETTLE_CYCLES=8 for this test) -> ignored; capture still occurs on time and stage=4.
- Assert rst while in S_WAIT with A=F, B=1 loaded -> all outputs 0 and stage=0 asynchronously, before the next clk edge; result_valid never rises.
